run_detect_ctrl: RTL and testbench

RUN_DETECT_CTRL -- requirements
Module: run_detect_ctrl

---
 rtl/run_detect_if.sv | 25 ++
 rtl/run_detect_ctrl.sv | 128 ++++++++++++
 tb/tb_run_detect_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_detect_if.sv
// Serial bit stream in, detection events out (valid/ready).
// master: bit source and event consumer; slave: the detector.
interface run_detect_if;
    logic din_valid;
    logic din;
    logic det_valid;
    logic det_ready;
    logic det_kind;

    modport master (
        output din_valid,
        output din,
        output det_ready,
        input  det_valid,
        input  det_kind
    );

    modport slave (
        input  din_valid,
        input  din,
        input  det_ready,
        output det_valid,
        output det_kind
    );
endinterface

// File: rtl/run_detect_ctrl.sv
// Run detector: flags every bit that extends a run of equal bits
// to length >= N, through a 1-deep valid/ready event buffer.
// Ports: clk, rst (sync, active high); cfg_we/cfg_len/cfg_mode
// (loaded only in IDLE); start/stop arm control; io carries
// din_valid/din in and det_valid/det_ready/det_kind out;
// det_count (saturating), busy, overflow (sticky drop flag).
module run_detect_ctrl (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_len,
    input  logic [1:0]          cfg_mode,
    input  logic                start,
    input  logic                stop,
    run_detect_if.slave         io,
    output logic [7:0]          det_count,
    output logic                busy,
    output logic                overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] n_q;
    logic [1:0] mode_q;
    logic [3:0] run_len;
    logic       last_bit;
    logic       det_valid_q;
    logic       det_kind_q;

    logic       sample;
    logic       same;
    logic [3:0] nxt_len;
    logic       permit;
    logic       hit;

    assign io.det_valid = det_valid_q;
    assign io.det_kind  = det_kind_q;

    always_comb begin
        sample  = (state == RUN) && io.din_valid;
        same    = (io.din == last_bit) && (run_len != 4'd0);
        nxt_len = 4'd1;
        if (same) begin
            nxt_len = (run_len == 4'd15) ? 4'd15 : run_len + 4'd1;
        end
        // mode 00: ones only, 01: zeros only, 1x: both
        permit = 1'b1;
        if (mode_q == 2'b00) begin
            permit = io.din;
        end else if (mode_q == 2'b01) begin
            permit = ~io.din;
        end
        hit = sample && permit && (nxt_len >= n_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            n_q         <= 4'd3;
            mode_q      <= 2'b10;
            run_len     <= 4'd0;
            last_bit    <= 1'b0;
            det_valid_q <= 1'b0;
            det_kind_q  <= 1'b0;
            det_count   <= 8'd0;
            overflow    <= 1'b0;
        end else begin
            // Output buffer runs in every state so a pending event
            // can still drain after stop.
            if (hit) begin
                if (!det_valid_q || io.det_ready) begin
                    det_valid_q <= 1'b1;
                    det_kind_q  <= io.din;
                end else begin
                    overflow <= 1'b1;
                end
                if (det_count != 8'hff) begin
                    det_count <= det_count + 8'd1;
                end
            end else if (io.det_ready) begin
                det_valid_q <= 1'b0;
            end

            if (sample) begin
                run_len  <= nxt_len;
                last_bit <= io.din;
            end

            unique case (state)
                IDLE: begin
                    if (cfg_we) begin
                        n_q    <= (cfg_len < 4'd2) ? 4'd2 : cfg_len;
                        mode_q <= cfg_mode;
                    end
                    if (start && !stop) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    run_len   <= 4'd0;
                    last_bit  <= 1'b0;
                    det_count <= 8'd0;
                    overflow  <= 1'b0;
                    state     <= RUN;
                    busy      <= 1'b1;
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Scoreboard bench for run_detect_ctrl: expected event kinds are
// queued by each scenario and drained on every accepted event.
module tb_run_detect_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [3:0] cfg_len;
    logic [1:0] cfg_mode;
    logic       start;
    logic       stop;
    logic [7:0] det_count;
    logic       busy;
    logic       overflow;

    run_detect_if io ();

    run_detect_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_len   (cfg_len),
        .cfg_mode  (cfg_mode),
        .start     (start),
        .stop      (stop),
        .io        (io.slave),
        .det_count (det_count),
        .busy      (busy),
        .overflow  (overflow)
    );

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard drain: an event is accepted at the next rising
    // edge whenever valid and ready are both high mid-cycle.
    always @(negedge clk) begin
        if (io.det_valid === 1'b1 && io.det_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got kind %0b, expected none",
                         io.det_kind);
            end else begin
                bit e;
                e = exp_q.pop_front();
                if (io.det_kind !== e) begin
                    errors++;
                    $display("FAIL event_kind: got %0b, expected %0b",
                             io.det_kind, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit b);
        io.din_valid = 1'b1;
        io.din = b;
        tick();
        io.din_valid = 1'b0;
    endtask

    task automatic write_cfg(input logic [3:0] l, input logic [1:0] m);
        cfg_we = 1'b1;
        cfg_len = l;
        cfg_mode = m;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic disarm();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({io.det_valid, io.det_kind, det_count, overflow, busy}
            !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v%0b k%0b c%0d o%0b b%0b, expected all 0",
                     io.det_valid, io.det_kind, det_count, overflow, busy);
        end
        arm();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_run: got %0b, expected 1", busy);
        end
    endtask

    task automatic test_defaults();
        io.det_ready = 1'b1;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        send(1); send(1); send(1); send(1);
        send(0); send(0); send(0);
        tick(); tick();
        checks++;
        if (det_count !== 8'd3) begin
            errors++;
            $display("FAIL default_count: got %0d, expected 3", det_count);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL default_missing: got %0d left, expected 0",
                     exp_q.size());
        end
        disarm();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle: got %0b, expected 0", busy);
        end
    endtask

    task automatic test_ones_only();
        write_cfg(4'd4, 2'b00);
        arm();
        for (int i = 0; i < 5; i++) send(0);
        send(1); send(1); send(1);
        checks++;
        if (io.det_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_detect: got %0b, expected 0", io.det_valid);
        end
        exp_q.push_back(1'b1);
        send(1);
        checks++;
        if (io.det_valid !== 1'b1 || io.det_kind !== 1'b1) begin
            errors++;
            $display("FAIL latency: got v%0b k%0b, expected v1 k1",
                     io.det_valid, io.det_kind);
        end
        tick(); tick();
        checks++;
        if (det_count !== 8'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ones_only_count: got %0d (%0d left), expected 1 (0 left)",
                     det_count, exp_q.size());
        end
        disarm();
    endtask

    task automatic test_backpressure();
        write_cfg(4'd3, 2'b10);
        io.det_ready = 1'b0;
        arm();
        send(1); send(1); send(1); send(1);
        checks++;
        if (io.det_valid !== 1'b1 || io.det_kind !== 1'b1 ||
            overflow !== 1'b1 || det_count !== 8'd2) begin
            errors++;
            $display("FAIL backpressure: got v%0b k%0b o%0b c%0d, expected v1 k1 o1 c2",
                     io.det_valid, io.det_kind, overflow, det_count);
        end
        exp_q.push_back(1'b1);
        io.det_ready = 1'b1;
        tick();
        checks++;
        if (io.det_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got v%0b (%0d left), expected v0 (0 left)",
                     io.det_valid, exp_q.size());
        end
        disarm();
    endtask

    task automatic test_saturate();
        write_cfg(4'd2, 2'b10);
        io.det_ready = 1'b1;
        arm();
        for (int i = 0; i < 299; i++) exp_q.push_back(1'b1);
        for (int i = 0; i < 300; i++) send(1);
        tick(); tick();
        checks++;
        if (det_count !== 8'd255) begin
            errors++;
            $display("FAIL count_sat: got %0d, expected 255", det_count);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL run_gap: got %0d missing, expected 0", exp_q.size());
        end
        disarm();
    endtask

    task automatic test_cfg_lock();
        write_cfg(4'd3, 2'b10);
        arm();
        cfg_we = 1'b1;
        cfg_len = 4'd7;
        tick();
        cfg_we = 1'b0;
        exp_q.push_back(1'b1);
        send(1); send(1); send(1);
        send(0);
        tick(); tick();
        checks++;
        if (det_count !== 8'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL cfg_ignored: got %0d (%0d left), expected 1 (0 left)",
                     det_count, exp_q.size());
        end
        disarm();
        write_cfg(4'd7, 2'b10);
        arm();
        for (int i = 0; i < 6; i++) send(1);
        checks++;
        if (det_count !== 8'd0) begin
            errors++;
            $display("FAIL n7_early: got %0d, expected 0", det_count);
        end
        exp_q.push_back(1'b1);
        send(1);
        tick(); tick();
        checks++;
        if (det_count !== 8'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL n7_count: got %0d (%0d left), expected 1 (0 left)",
                     det_count, exp_q.size());
        end
        disarm();
        write_cfg(4'd1, 2'b10);
        arm();
        send(1);
        exp_q.push_back(1'b1);
        send(1);
        send(0);
        exp_q.push_back(1'b0);
        send(0);
        tick(); tick();
        checks++;
        if (det_count !== 8'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL len1_as2: got %0d (%0d left), expected 2 (0 left)",
                     det_count, exp_q.size());
        end
        disarm();
    endtask

    task automatic test_rst_mid_run();
        do_reset();
        arm();
        send(1); send(1);
        rst = 1'b1;
        io.din_valid = 1'b1;
        io.din = 1'b1;
        tick();
        io.din_valid = 1'b0;
        rst = 1'b0;
        tick(); tick();
        checks++;
        if ({io.det_valid, io.det_kind, det_count, overflow, busy}
            !== 12'd0) begin
            errors++;
            $display("FAIL rst_mid_run: got v%0b k%0b c%0d o%0b b%0b, expected all 0",
                     io.det_valid, io.det_kind, det_count, overflow, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_queue: got %0d left, expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_len = 4'd0;
        cfg_mode = 2'b00;
        start = 1'b0;
        stop = 1'b0;
        io.din_valid = 1'b0;
        io.din = 1'b0;
        io.det_ready = 1'b1;
        test_reset();
        test_defaults();
        test_ones_only();
        test_backpressure();
        test_saturate();
        test_cfg_lock();
        test_rst_mid_run();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
